// File: rtl/hazard_fwd_ctrl.sv
// Register-fetch hazard controller: tracks in-flight destinations, raises
// load-use / flag-use stalls and produces registered EX operand forwarding selects.
module hazard_fwd_ctrl #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_ab,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_setflag,
    input  logic             id_useflag,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] XZR = 5'(NREG - 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX slot keeps every field; MEM only needs "writes rd" for forwarding.
    // WB-slot producers are covered by the inverted-clock register file write,
    // so nothing about them has to be kept once they leave MEM.
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_setflag;
    logic       mem_writes;
    logic [4:0] mem_rd;

    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       load_use;
    logic       flag_use;
    logic       issue;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    always_comb begin
        ex_hit_a  = ex_valid & ex_regwrite & (ex_rd == id_rn) & (id_rn != XZR);
        ex_hit_b  = ex_valid & ex_regwrite & (ex_rd == id_ab) & (id_ab != XZR);
        mem_hit_a = mem_writes & (mem_rd == id_rn) & (id_rn != XZR);
        mem_hit_b = mem_writes & (mem_rd == id_ab) & (id_ab != XZR);

        load_use = ex_memread & ((id_use_a & ex_hit_a) | (id_use_b & ex_hit_b));
        flag_use = id_useflag & ex_valid & ex_setflag;
        stall    = id_valid & ~flush & (load_use | flag_use);
        issue    = id_valid & ~stall & ~flush;

        fwd_a_nxt = SEL_RF;
        if (issue && id_use_a) begin
            if (ex_hit_a)       fwd_a_nxt = SEL_EX;
            else if (mem_hit_a) fwd_a_nxt = SEL_MEM;
        end

        fwd_b_nxt = SEL_RF;
        if (issue && id_use_b) begin
            if (ex_hit_b)       fwd_b_nxt = SEL_EX;
            else if (mem_hit_b) fwd_b_nxt = SEL_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_setflag  <= 1'b0;
            mem_writes  <= 1'b0;
            mem_rd      <= '0;
            fwd_a       <= SEL_RF;
            fwd_b       <= SEL_RF;
            stall_cnt   <= '0;
        end else begin
            mem_writes  <= ex_valid & ex_regwrite;
            mem_rd      <= ex_rd;
            ex_valid    <= issue;
            ex_rd       <= id_rd;
            ex_regwrite <= issue & id_regwrite;
            ex_memread  <= issue & id_memread;
            ex_setflag  <= issue & id_setflag;
            fwd_a       <= fwd_a_nxt;
            fwd_b       <= fwd_b_nxt;
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed instruction table, then load-use saturation
// on a narrow-counter instance, then random traffic against a pipeline-age model.
module tb_hazard_fwd_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rn;
        logic [4:0] ab;
        logic       ua;
        logic       ub;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       sf;
        logic       uf;
        logic       fl;
    } instr_t;

    typedef struct {
        instr_t     in;
        logic       rst;
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_a, id_use_b, id_regwrite, id_memread;
    logic        id_setflag, id_useflag, flush;
    logic [4:0]  id_rn, id_ab, id_rd;
    logic        stall, stall_s;
    logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_ab(id_ab),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_setflag(id_setflag), .id_useflag(id_useflag),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.NREG(32), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_ab(id_ab),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_setflag(id_setflag), .id_useflag(id_useflag),
        .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
    );

    // Reference model: age[0] is the instruction now in EX, age[1] the one in MEM.
    instr_t     age [2];
    logic [1:0] m_fa, m_fb;
    int         m_cnt, m_cnt_s;

    function automatic instr_t ins(logic v, logic [4:0] rn, logic [4:0] ab, logic ua, logic ub,
                                   logic [4:0] rd, logic rw, logic mr, logic sf, logic uf);
        instr_t r;
        r.v = v; r.rn = rn; r.ab = ab; r.ua = ua; r.ub = ub; r.rd = rd;
        r.rw = rw; r.mr = mr; r.sf = sf; r.uf = uf; r.fl = 1'b0;
        return r;
    endfunction

    function automatic instr_t nop();           return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic instr_t alu(int d, int n, int m);
        return ins(1, 5'(n), 5'(m), 1, 1, 5'(d), 1, 0, 0, 0);
    endfunction
    function automatic instr_t ldur(int d, int n); return ins(1, 5'(n), 0, 1, 0, 5'(d), 1, 1, 0, 0); endfunction
    function automatic instr_t adds(int d, int n, int m);
        return ins(1, 5'(n), 5'(m), 1, 1, 5'(d), 1, 0, 1, 0);
    endfunction
    function automatic instr_t bcond();         return ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); endfunction
    function automatic instr_t flushed(instr_t i);
        instr_t r = i;
        r.fl = 1'b1;
        return r;
    endfunction

    function automatic vec_t mkv(instr_t i, logic rst, logic st, int fa, int fb);
        vec_t r;
        r.in = i; r.rst = rst; r.st = st; r.fa = 2'(fa); r.fb = 2'(fb);
        return r;
    endfunction

    function automatic bit writes(logic [4:0] a, instr_t p);
        return p.v && p.rw && (p.rd == a) && (a != 5'd31);
    endfunction

    // Select code is 1 + age of the youngest in-flight producer, 0 if none.
    function automatic logic [1:0] youngest(logic [4:0] a);
        for (int k = 0; k < 2; k++)
            if (writes(a, age[k])) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit model_stall(instr_t i);
        bit lu, fu;
        lu = age[0].mr && ((i.ua && writes(i.rn, age[0])) || (i.ub && writes(i.ab, age[0])));
        fu = i.uf && age[0].v && age[0].sf;
        return i.v && !i.fl && (lu || fu);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        age[0] = nop(); age[1] = nop();
        m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    // One clock cycle: drive ID, check mid-cycle against model (and table), advance model.
    task automatic run(input instr_t i, input logic rst, input bit tab, input logic st_e,
                       input logic [1:0] fa_e, input logic [1:0] fb_e, input int cnt_e);
        bit         ms, issue;
        logic [1:0] nfa, nfb;
        reset = rst; id_valid = i.v; id_rn = i.rn; id_ab = i.ab; id_use_a = i.ua;
        id_use_b = i.ub; id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
        id_setflag = i.sf; id_useflag = i.uf; flush = i.fl;
        #4;
        ms = model_stall(i);
        chk("stall", stall, ms);
        chk("fwd_a", fwd_a, m_fa);
        chk("fwd_b", fwd_b, m_fb);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("stall_cnt_sat", stall_cnt_s, m_cnt_s);
        chk("sat_inst_fwd", {stall_s, fwd_a_s, fwd_b_s}, {ms, m_fa, m_fb});
        if (tab) begin
            chk("tab_stall", stall, st_e);
            chk("tab_fwd_a", fwd_a, fa_e);
            chk("tab_fwd_b", fwd_b, fb_e);
            chk("tab_cnt", stall_cnt, cnt_e);
        end
        if (rst) begin
            model_clear();
        end else begin
            issue = i.v && !ms && !i.fl;
            nfa = (issue && i.ua) ? youngest(i.rn) : 2'd0;
            nfb = (issue && i.ub) ? youngest(i.ab) : 2'd0;
            m_fa = nfa; m_fb = nfb;
            age[1] = age[0];
            age[0] = issue ? i : nop();
            if (ms && m_cnt < 65535) m_cnt++;
            if (ms && m_cnt_s < 7) m_cnt_s++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        int k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    vec_t tab [$];
    int   tab_cnt;
    int   cnt_before;

    initial begin
        reset = 1'b1; id_valid = 0; id_rn = 0; id_ab = 0; id_use_a = 0; id_use_b = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; id_setflag = 0; id_useflag = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("reset_stall", stall, 0);
        chk("reset_fwd_a", fwd_a, 0);
        chk("reset_fwd_b", fwd_b, 0);
        chk("reset_cnt", stall_cnt, 0);

        // {instr, reset, stall now, fwd_a now, fwd_b now}; fwd columns belong to the previous row's instr
        tab.push_back(mkv(alu(1, 2, 3),   0, 0, 0, 0));
        tab.push_back(mkv(alu(2, 1, 3),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 1, 0));
        tab.push_back(mkv(alu(1, 5, 6),   0, 0, 0, 0));
        tab.push_back(mkv(alu(9, 10, 11), 0, 0, 0, 0));
        tab.push_back(mkv(alu(4, 5, 1),   0, 0, 0, 0));
        tab.push_back(mkv(alu(1, 2, 3),   0, 0, 0, 2));
        tab.push_back(mkv(alu(1, 2, 3),   0, 0, 0, 0));
        tab.push_back(mkv(alu(5, 1, 1),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 1, 1));
        tab.push_back(mkv(ldur(7, 2),     0, 0, 0, 0));
        tab.push_back(mkv(alu(8, 7, 7),   0, 1, 0, 0));
        tab.push_back(mkv(alu(8, 7, 7),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 2, 2));
        tab.push_back(mkv(adds(9, 2, 3),  0, 0, 0, 0));
        tab.push_back(mkv(bcond(),        0, 1, 0, 0));
        tab.push_back(mkv(bcond(),        0, 0, 0, 0));
        tab.push_back(mkv(alu(31, 2, 3),  0, 0, 0, 0));
        tab.push_back(mkv(alu(4, 31, 31), 0, 0, 0, 0));
        tab.push_back(mkv(ldur(31, 2),    0, 0, 0, 0));
        tab.push_back(mkv(alu(5, 31, 3),  0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 0, 0));
        tab.push_back(mkv(ldur(7, 2),     0, 0, 0, 0));
        tab.push_back(mkv(flushed(alu(8, 7, 7)), 0, 0, 0, 0));
        tab.push_back(mkv(alu(8, 7, 7),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 2, 2));
        tab.push_back(mkv(alu(1, 2, 3),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          1, 0, 0, 0));
        tab.push_back(mkv(alu(2, 1, 1),   0, 0, 0, 0));
        tab.push_back(mkv(nop(),          0, 0, 0, 0));

        tab_cnt = 0;
        foreach (tab[n]) begin
            run(tab[n].in, tab[n].rst, 1'b1, tab[n].st, tab[n].fa, tab[n].fb, tab_cnt);
            if (tab[n].rst) tab_cnt = 0;
            else if (tab[n].st) tab_cnt++;
        end

        // Ten load-use stalls: narrow counter must pin at 7, wide one keeps counting.
        cnt_before = m_cnt;
        for (int k = 0; k < 10; k++) begin
            run(ldur(7, 2), 0, 0, 0, 0, 0, 0);
            run(alu(8, 7, 7), 0, 0, 0, 0, 0, 0);
            run(alu(8, 7, 7), 0, 0, 0, 0, 0, 0);
        end
        #3;
        chk("sat_all_ones", stall_cnt_s, 7);
        chk("wide_cnt_after_10", stall_cnt, cnt_before + 10);
        #1;
        run(nop(), 1, 0, 0, 0, 0, 0);
        #3;
        chk("sat_reset_zero", stall_cnt_s, 0);
        chk("wide_reset_zero", stall_cnt, 0);
        #1;

        for (int k = 0; k < 3000; k++) begin
            instr_t r;
            r.v  = ($urandom_range(0, 9) != 0);
            r.rn = rnd_reg(); r.ab = rnd_reg(); r.rd = rnd_reg();
            r.ua = $urandom_range(0, 1); r.ub = $urandom_range(0, 1);
            r.rw = ($urandom_range(0, 3) != 0);
            r.mr = ($urandom_range(0, 2) == 0);
            r.sf = $urandom_range(0, 1); r.uf = ($urandom_range(0, 3) == 0);
            r.fl = ($urandom_range(0, 9) == 0);
            run(r, ($urandom_range(0, 99) == 0), 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
